// File: rtl/expr_seq_ctrl.sv
// expr_seq_ctrl: replays a loadable program of control words onto the
// expression-solver datapath, one word per cycle, with hold, abort and
// restart-from-done.
//
// state  | meaning
// -------+----------------------------------------------------------------
// S_IDLE | no run; ctrl=0; program writes accepted; start begins a run
// S_RUN  | one word per cycle on ctrl; hold freezes, abort returns to IDLE
// S_DONE | run finished; ctrl=0, completed=1; writes accepted; start reruns
module expr_seq_ctrl #(
    parameter int CTRL_W = 10,
    parameter int DEPTH  = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              hold,
    input  logic              prog_we,
    input  logic [AW-1:0]     prog_addr,
    input  logic [CTRL_W-1:0] prog_data,
    input  logic              prog_last,
    output logic [CTRL_W-1:0] ctrl,
    output logic [AW-1:0]     step,
    output logic              busy,
    output logic              completed,
    output logic              prog_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [AW-1:0] LAST_STEP = AW'(DEPTH - 1);

    state_t            state;
    state_t            state_nxt;
    logic [CTRL_W-1:0] ctrl_nxt;
    logic [AW-1:0]     step_nxt;
    logic [AW-1:0]     step_inc;
    logic              wr_ok;

    logic [CTRL_W-1:0] mem_word [DEPTH];
    logic              mem_last [DEPTH];

    assign step_inc  = step + 1'b1;
    // Writes are only legal while no run is replaying the memory.
    assign wr_ok     = prog_we && (state != S_RUN);
    assign busy      = (state == S_RUN);
    assign completed = (state == S_DONE);

    // Next-state, next control word and next step index.
    always_comb begin
        state_nxt = state;
        ctrl_nxt  = ctrl;
        step_nxt  = step;
        case (state)
            S_IDLE, S_DONE: begin
                ctrl_nxt = '0;
                // A write in the same cycle as start wins; start is dropped.
                if (start && !prog_we) begin
                    state_nxt = S_RUN;
                    step_nxt  = '0;
                    ctrl_nxt  = mem_word[0];
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                    ctrl_nxt  = '0;
                    step_nxt  = '0;
                end else if (!hold) begin
                    // The DEPTH-1 check stops a program without a last bit
                    // from wrapping back to step 0.
                    if (mem_last[step] || (step == LAST_STEP)) begin
                        state_nxt = S_DONE;
                        ctrl_nxt  = '0;
                    end else begin
                        step_nxt = step_inc;
                        ctrl_nxt = mem_word[step_inc];
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                ctrl_nxt  = '0;
                step_nxt  = '0;
            end
        endcase
    end

    // State, output and error-pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            ctrl     <= '0;
            step     <= '0;
            prog_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            ctrl     <= ctrl_nxt;
            step     <= step_nxt;
            prog_err <= prog_we && (state == S_RUN);
        end
    end

    // Program memory: cleared by reset, written only outside a run.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_word[i] <= '0;
                mem_last[i] <= 1'b0;
            end
        end else if (wr_ok) begin
            mem_word[prog_addr] <= prog_data;
            mem_last[prog_addr] <= prog_last;
        end
    end

endmodule

// File: tb/tb_expr_seq_ctrl.sv
// Bench for expr_seq_ctrl: directed program scenarios followed by random
// traffic, all checked cycle by cycle against a queue-based reference model.
module tb_expr_seq_ctrl;

    localparam int CTRL_W = 10;
    localparam int DEPTH  = 8;
    localparam int AW     = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              hold = 1'b0;
    logic              prog_we = 1'b0;
    logic [AW-1:0]     prog_addr = '0;
    logic [CTRL_W-1:0] prog_data = '0;
    logic              prog_last = 1'b0;
    logic [CTRL_W-1:0] ctrl;
    logic [AW-1:0]     step;
    logic              busy;
    logic              completed;
    logic              prog_err;

    int n_chk = 0;
    int n_err = 0;

    // reference model: program contents, mode and queue of steps still to emit
    logic [CTRL_W-1:0] m_word [DEPTH];
    bit                m_last [DEPTH];
    int                m_q [$];
    int                m_mode = 0;      // 0 idle, 1 running, 2 done
    logic [CTRL_W-1:0] e_ctrl = '0;
    int                e_step = 0;
    bit                e_err = 1'b0;

    expr_seq_ctrl #(.CTRL_W(CTRL_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .hold(hold),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .prog_last(prog_last), .ctrl(ctrl), .step(step), .busy(busy),
        .completed(completed), .prog_err(prog_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_begin_run();
        m_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            m_q.push_back(i);
            if (m_last[i]) break;
        end
        m_mode = 1;
        e_step = m_q.pop_front();
        e_ctrl = m_word[e_step];
    endtask

    // apply inputs for one edge, advance the model, compare after the edge
    task automatic cyc(input bit r, input bit s, input bit a, input bit h,
                       input bit we, input int addr, input int data, input bit lst);
        rst = r; start = s; abort = a; hold = h; prog_we = we;
        prog_addr = AW'(addr); prog_data = CTRL_W'(data); prog_last = lst;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_word[i] = '0;
                m_last[i] = 1'b0;
            end
            m_q.delete();
            m_mode = 0; e_ctrl = '0; e_step = 0; e_err = 1'b0;
        end else begin
            e_err = we && (m_mode == 1);
            if (m_mode != 1) begin
                if (we) begin
                    m_word[addr] = CTRL_W'(data);
                    m_last[addr] = lst;
                end else if (s) begin
                    model_begin_run();
                end
            end else if (a) begin
                m_q.delete();
                m_mode = 0; e_ctrl = '0; e_step = 0;
            end else if (!h) begin
                if (m_q.size() == 0) begin
                    m_mode = 2; e_ctrl = '0;
                end else begin
                    e_step = m_q.pop_front();
                    e_ctrl = m_word[e_step];
                end
            end
        end
        #1;
        chk("ctrl", 32'(ctrl), 32'(e_ctrl));
        chk("busy", 32'(busy), 32'(m_mode == 1));
        chk("completed", 32'(completed), 32'(m_mode == 2));
        chk("prog_err", 32'(prog_err), 32'(e_err));
        if (m_mode != 2) chk("step", 32'(step), 32'(e_step));
        rst = 0; start = 0; abort = 0; hold = 0; prog_we = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic load3();
        cyc(0, 0, 0, 0, 1, 0, 'h041, 0);
        cyc(0, 0, 0, 0, 1, 1, 'h012, 0);
        cyc(0, 0, 0, 0, 1, 2, 'h3A4, 1);
    endtask

    int done_at_a;
    int done_at_b;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_word[i] = '0;
            m_last[i] = 1'b0;
        end
        #1;
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_ctrl", 32'(ctrl), 0);
        chk("reset_busy", 32'(busy), 0);

        // basic three-word program
        load3();
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        chk("tp1_w0", 32'(ctrl), 'h041);
        idle(1);
        chk("tp1_w1", 32'(ctrl), 'h012);
        idle(1);
        chk("tp1_w2", 32'(ctrl), 'h3A4);
        chk("tp1_s2", 32'(step), 2);
        done_at_a = 0;
        for (int i = 1; i <= 4; i++) begin
            idle(1);
            if (completed && done_at_a == 0) done_at_a = i;
        end
        chk("tp1_done_held", 32'(completed), 1);

        // restart from DONE with a two-cycle hold on step 1
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        idle(1);
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        chk("tp2_hold_w1", 32'(ctrl), 'h012);
        done_at_b = 0;
        for (int i = 1; i <= 6; i++) begin
            idle(1);
            if (completed && done_at_b == 0) done_at_b = i;
        end
        chk("tp2_hold_delay", 32'(done_at_b), 32'(done_at_a + 1));

        // abort at step 1, then replay
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        idle(1);
        cyc(0, 0, 1, 0, 0, 0, 0, 0);
        chk("tp3_abort_completed", 32'(completed), 0);
        idle(2);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        chk("tp3_replay_w0", 32'(ctrl), 'h041);
        idle(4);

        // full program without any last bit
        for (int i = 0; i < DEPTH; i++)
            cyc(0, 0, 0, 0, 1, i, $urandom_range(1, 1023), 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        idle(DEPTH + 2);
        chk("tp4_done", 32'(completed), 1);

        // write rejected during run, write+start in DONE
        load3();
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 'h155, 1);
        chk("tp5_err", 32'(prog_err), 1);
        idle(1);
        chk("tp5_err_pulse", 32'(prog_err), 0);
        idle(3);
        cyc(0, 1, 0, 0, 1, 1, 'h2AA, 0);
        chk("tp5_stay_done", 32'(completed), 1);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        chk("tp5_orig_w0", 32'(ctrl), 'h041);
        idle(DEPTH + 1);

        // reset mid-run clears memory
        load3();
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        idle(2);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        chk("tp6_rst_ctrl", 32'(ctrl), 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        idle(DEPTH + 2);

        // random traffic
        for (int n = 0; n < 4000; n++) begin
            cyc(($urandom_range(0, 299) == 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 5) == 0),
                $urandom_range(0, DEPTH - 1),
                $urandom_range(0, 1023),
                ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
